// File: rtl/pipe_pkg.sv
// Shared pipeline types for the decode/execute boundary.
//   reg_idx_t : 5-bit architectural register index
//   ZeroReg   : hard-wired zero register index
//   fwd_sel_t : operand source chosen by the forwarding mux
package pipe_pkg;

  typedef logic [4:0] reg_idx_t;

  localparam reg_idx_t ZeroReg = 5'd0;

  typedef enum logic [1:0] {
    FWD_ZERO,
    FWD_EX,
    FWD_MEM,
    FWD_RF
  } fwd_sel_t;

endpackage

// File: rtl/operand_fwd_mux.sv
// Per-operand forwarding selector (purely combinational).
// Ports:
//   idx                                 : source register index of the operand
//   ex_wen, ex_is_load, ex_dst, ex_result : EX-stage producer
//   mem_wen, mem_dst, mem_result          : MEM-stage producer
//   rf_data                             : register-file read data for idx
//   operand                             : selected operand value
module operand_fwd_mux
  import pipe_pkg::*;
(
  input  reg_idx_t    idx,
  input  logic        ex_wen,
  input  logic        ex_is_load,
  input  reg_idx_t    ex_dst,
  input  logic [31:0] ex_result,
  input  logic        mem_wen,
  input  reg_idx_t    mem_dst,
  input  logic [31:0] mem_result,
  input  logic [31:0] rf_data,
  output logic [31:0] operand
);

  fwd_sel_t sel;

  // A load in EX has no data yet; the stage stalls on it, so it is never a source here.
  always_comb begin
    sel = FWD_RF;
    if (idx == ZeroReg) begin
      sel = FWD_ZERO;
    end else if (ex_wen && !ex_is_load && (ex_dst == idx)) begin
      sel = FWD_EX;
    end else if (mem_wen && (mem_dst == idx)) begin
      sel = FWD_MEM;
    end
  end

  always_comb begin
    operand = 32'h0;
    unique case (sel)
      FWD_ZERO: operand = 32'h0;
      FWD_EX:   operand = ex_result;
      FWD_MEM:  operand = mem_result;
      FWD_RF:   operand = rf_data;
      default:  operand = 32'h0;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline stage with a two-entry hold (A, B).
// Slot A holds captured decode fields while the register file read completes;
// slot B holds the registered, forwarded operands presented to EX.
// Ports:
//   clk, rst (sync, active-low), flush
//   in_valid/in_ready, in_rs/in_rt/in_rd, in_ctrl, in_imm : decode side
//   rf_addr_1/2 -> rf_data_1/2 (one-cycle read latency)
//   ex_wen/ex_is_load/ex_dst/ex_result, mem_wen/mem_dst/mem_result : bypass sources
//   out_valid/out_ready, out_op_a/out_op_b, out_rd, out_ctrl, out_imm : EX side
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [31:0]       in_imm,
  output logic [4:0]        rf_addr_1,
  output logic [4:0]        rf_addr_2,
  input  logic [31:0]       rf_data_1,
  input  logic [31:0]       rf_data_2,
  input  logic              ex_wen,
  input  logic              ex_is_load,
  input  logic [4:0]        ex_dst,
  input  logic [31:0]       ex_result,
  input  logic              mem_wen,
  input  logic [4:0]        mem_dst,
  input  logic [31:0]       mem_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_op_a,
  output logic [31:0]       out_op_b,
  output logic [4:0]        out_rd,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [31:0]       out_imm
);

  // Slot A
  logic              a_vld_q;
  reg_idx_t          a_rs_q, a_rt_q, a_rd_q;
  logic [CTRL_W-1:0] a_ctrl_q;
  logic [31:0]       a_imm_q;

  // Slot B
  logic              b_vld_q;
  logic [31:0]       b_op_a_q, b_op_b_q;
  reg_idx_t          b_rd_q;
  logic [CTRL_W-1:0] b_ctrl_q;
  logic [31:0]       b_imm_q;

  logic        haz, a_adv, a_load;
  logic [31:0] fwd_a, fwd_b;

  always_comb begin
    haz = a_vld_q && ex_wen && ex_is_load && (ex_dst != ZeroReg) &&
          ((ex_dst == a_rs_q) || (ex_dst == a_rt_q));
    a_adv    = a_vld_q && !haz && (!b_vld_q || out_ready);
    // Flush empties both slots, so the stage reports ready while dropping input.
    in_ready = !a_vld_q || a_adv || flush;
    a_load   = in_valid && in_ready && !flush;
    // Steer the RF read to whatever will sit in A next cycle so rf_data lines up with A.
    rf_addr_1 = a_load ? in_rs : a_rs_q;
    rf_addr_2 = a_load ? in_rt : a_rt_q;
  end

  operand_fwd_mux u_fwd_a (
    .idx        (a_rs_q),
    .ex_wen     (ex_wen),
    .ex_is_load (ex_is_load),
    .ex_dst     (ex_dst),
    .ex_result  (ex_result),
    .mem_wen    (mem_wen),
    .mem_dst    (mem_dst),
    .mem_result (mem_result),
    .rf_data    (rf_data_1),
    .operand    (fwd_a)
  );

  operand_fwd_mux u_fwd_b (
    .idx        (a_rt_q),
    .ex_wen     (ex_wen),
    .ex_is_load (ex_is_load),
    .ex_dst     (ex_dst),
    .ex_result  (ex_result),
    .mem_wen    (mem_wen),
    .mem_dst    (mem_dst),
    .mem_result (mem_result),
    .rf_data    (rf_data_2),
    .operand    (fwd_b)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_vld_q  <= 1'b0;
      a_rs_q   <= ZeroReg;
      a_rt_q   <= ZeroReg;
      a_rd_q   <= ZeroReg;
      a_ctrl_q <= '0;
      a_imm_q  <= 32'h0;
      b_vld_q  <= 1'b0;
      b_op_a_q <= 32'h0;
      b_op_b_q <= 32'h0;
      b_rd_q   <= ZeroReg;
      b_ctrl_q <= '0;
      b_imm_q  <= 32'h0;
    end else if (flush) begin
      a_vld_q <= 1'b0;
      b_vld_q <= 1'b0;
    end else begin
      if (a_load) begin
        a_vld_q  <= 1'b1;
        a_rs_q   <= in_rs;
        a_rt_q   <= in_rt;
        a_rd_q   <= in_rd;
        a_ctrl_q <= in_ctrl;
        a_imm_q  <= in_imm;
      end else if (a_adv) begin
        a_vld_q <= 1'b0;
      end

      if (a_adv) begin
        b_vld_q  <= 1'b1;
        b_op_a_q <= fwd_a;
        b_op_b_q <= fwd_b;
        b_rd_q   <= a_rd_q;
        b_ctrl_q <= a_ctrl_q;
        b_imm_q  <= a_imm_q;
      end else if (out_ready) begin
        b_vld_q <= 1'b0;
      end
    end
  end

  assign out_valid = b_vld_q;
  assign out_op_a  = b_op_a_q;
  assign out_op_b  = b_op_b_q;
  assign out_rd    = b_rd_q;
  assign out_ctrl  = b_ctrl_q;
  assign out_imm   = b_imm_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: a table of single-instruction forwarding
// vectors plus directed sequences for throughput, load-use stall, backpressure,
// flush and mid-stream reset. The register file is a small synchronous-read model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [15:0] in_ctrl;
  logic [31:0] in_imm;
  logic [4:0]  rf_addr_1, rf_addr_2;
  logic [31:0] rf_data_1, rf_data_2;
  logic        ex_wen, ex_is_load;
  logic [4:0]  ex_dst;
  logic [31:0] ex_result;
  logic        mem_wen;
  logic [4:0]  mem_dst;
  logic [31:0] mem_result;
  logic        out_valid, out_ready;
  logic [31:0] out_op_a, out_op_b;
  logic [4:0]  out_rd;
  logic [15:0] out_ctrl;
  logic [31:0] out_imm;

  int checks = 0;
  int errors = 0;

  logic [31:0] rf_mem [32];

  id_ex_stage #(.CTRL_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_rd      (in_rd),
    .in_ctrl    (in_ctrl),
    .in_imm     (in_imm),
    .rf_addr_1  (rf_addr_1),
    .rf_addr_2  (rf_addr_2),
    .rf_data_1  (rf_data_1),
    .rf_data_2  (rf_data_2),
    .ex_wen     (ex_wen),
    .ex_is_load (ex_is_load),
    .ex_dst     (ex_dst),
    .ex_result  (ex_result),
    .mem_wen    (mem_wen),
    .mem_dst    (mem_dst),
    .mem_result (mem_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_op_a   (out_op_a),
    .out_op_b   (out_op_b),
    .out_rd     (out_rd),
    .out_ctrl   (out_ctrl),
    .out_imm    (out_imm)
  );

  always #5 clk = ~clk;

  // Register file model: one-cycle read latency.
  always @(posedge clk) begin
    rf_data_1 <= rf_mem[rf_addr_1];
    rf_data_2 <= rf_mem[rf_addr_2];
  end

  function automatic logic [31:0] rfv(input int i);
    return (i == 0) ? 32'h1 : 32'(i << 4);
  endfunction

  typedef struct {
    logic [4:0]  rs, rt, rd;
    logic        ex_wen, ex_is_load;
    logic [4:0]  ex_dst;
    logic [31:0] ex_result;
    logic        mem_wen;
    logic [4:0]  mem_dst;
    logic [31:0] mem_result;
    logic [31:0] exp_a, exp_b;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bypass();
    ex_wen = 1'b0; ex_is_load = 1'b0; ex_dst = 5'd0; ex_result = 32'h0;
    mem_wen = 1'b0; mem_dst = 5'd0; mem_result = 32'h0;
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    in_valid = 1'b1;
    in_rs = rs; in_rt = rt; in_rd = rd;
    in_ctrl = 16'hC000 | 16'(rd);
    in_imm = 32'h1000_0000 | 32'(rd);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf_mem[i] = rfv(i);

    //            rs     rt     rd    exw   exl   exd    exres         mw    md     mres          exp_a         exp_b
    vecs[0] = '{5'd3,  5'd4,  5'd1, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        32'h30,       32'h40};
    vecs[1] = '{5'd5,  5'd6,  5'd2, 1'b1, 1'b0, 5'd5,  32'hAA,       1'b1, 5'd5,  32'hBB,       32'hAA,       32'h60};
    vecs[2] = '{5'd5,  5'd6,  5'd3, 1'b0, 1'b0, 5'd5,  32'hAA,       1'b1, 5'd5,  32'hBB,       32'hBB,       32'h60};
    vecs[3] = '{5'd0,  5'd2,  5'd4, 1'b1, 1'b0, 5'd0,  32'hFF,       1'b1, 5'd0,  32'hEE,       32'h0,        32'h20};
    vecs[4] = '{5'd9,  5'd9,  5'd5, 1'b1, 1'b0, 5'd9,  32'h1234,     1'b0, 5'd0,  32'h0,        32'h1234,     32'h1234};
    vecs[5] = '{5'd8,  5'd10, 5'd6, 1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd10, 32'hCAFE,     32'h80,       32'hCAFE};
    vecs[6] = '{5'd11, 5'd12, 5'd7, 1'b1, 1'b0, 5'd12, 32'h5555,     1'b1, 5'd11, 32'h6666,     32'h6666,     32'h5555};
    vecs[7] = '{5'd13, 5'd13, 5'd8, 1'b1, 1'b0, 5'd13, 32'h7777,     1'b1, 5'd13, 32'h8888,     32'h7777,     32'h7777};

    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0; in_ctrl = 16'h0; in_imm = 32'h0;
    idle_bypass();

    // Reset state
    cyc(); cyc();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_op_a", out_op_a, 32'h0);
    chk("rst_op_b", out_op_b, 32'h0);
    chk("rst_rd", 32'(out_rd), 32'd0);
    chk("rst_ctrl", 32'(out_ctrl), 32'd0);
    chk("rst_imm", out_imm, 32'h0);
    rst = 1'b1;
    cyc();
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Single-instruction forwarding table, output expected two cycles after accept
    for (int i = 0; i < 8; i++) begin
      ex_wen = vecs[i].ex_wen; ex_is_load = vecs[i].ex_is_load;
      ex_dst = vecs[i].ex_dst; ex_result = vecs[i].ex_result;
      mem_wen = vecs[i].mem_wen; mem_dst = vecs[i].mem_dst; mem_result = vecs[i].mem_result;
      drive(vecs[i].rs, vecs[i].rt, vecs[i].rd);
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
      cyc();
      in_valid = 1'b0;
      chk($sformatf("v%0d_early_valid", i), 32'(out_valid), 32'd0);
      cyc();
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d_op_a", i), out_op_a, vecs[i].exp_a);
      chk($sformatf("v%0d_op_b", i), out_op_b, vecs[i].exp_b);
      chk($sformatf("v%0d_rd", i), 32'(out_rd), 32'(vecs[i].rd));
      chk($sformatf("v%0d_ctrl", i), 32'(out_ctrl), 32'(16'hC000 | 16'(vecs[i].rd)));
      chk($sformatf("v%0d_imm", i), out_imm, 32'h1000_0000 | 32'(vecs[i].rd));
      cyc();
    end
    idle_bypass();

    // Throughput: four back-to-back instructions, one output per cycle
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        drive(5'(k + 1), 5'(k + 2), 5'(16 + k));
        #1;
        chk($sformatf("tp%0d_in_ready", k), 32'(in_ready), 32'd1);
      end else begin
        in_valid = 1'b0;
      end
      if (k >= 2) begin
        chk($sformatf("tp%0d_out_valid", k), 32'(out_valid), 32'd1);
        chk($sformatf("tp%0d_rd", k), 32'(out_rd), 32'(16 + k - 2));
        chk($sformatf("tp%0d_op_a", k), out_op_a, rfv(k - 1));
        chk($sformatf("tp%0d_op_b", k), out_op_b, rfv(k));
      end
      cyc();
    end
    chk("tp_drained", 32'(out_valid), 32'd0);

    // Load-use stall on rt
    drive(5'd1, 5'd7, 5'd20);
    #1;
    chk("lu_c0_in_ready", 32'(in_ready), 32'd1);
    cyc();
    in_valid = 1'b0;
    ex_wen = 1'b1; ex_is_load = 1'b1; ex_dst = 5'd7; ex_result = 32'hDEAD;
    #1;
    chk("lu_c1_in_ready", 32'(in_ready), 32'd0);
    chk("lu_c1_rf_addr_2", 32'(rf_addr_2), 32'd7);
    chk("lu_c1_out_valid", 32'(out_valid), 32'd0);
    cyc();
    ex_wen = 1'b0; ex_is_load = 1'b0; ex_dst = 5'd0;
    mem_wen = 1'b1; mem_dst = 5'd7; mem_result = 32'h777;
    #1;
    chk("lu_c2_in_ready", 32'(in_ready), 32'd1);
    chk("lu_c2_rf_addr_2", 32'(rf_addr_2), 32'd7);
    chk("lu_c2_out_valid", 32'(out_valid), 32'd0);
    cyc();
    idle_bypass();
    chk("lu_c3_out_valid", 32'(out_valid), 32'd1);
    chk("lu_c3_op_a", out_op_a, 32'h10);
    chk("lu_c3_op_b", out_op_b, 32'h777);
    chk("lu_c3_rd", 32'(out_rd), 32'd20);
    cyc();

    // Backpressure: out_ready low for four cycles, three offers, two held
    out_ready = 1'b0;
    drive(5'd1, 5'd2, 5'd21);
    #1;
    chk("bp_c0_in_ready", 32'(in_ready), 32'd1);
    cyc();
    drive(5'd3, 5'd4, 5'd22);
    #1;
    chk("bp_c1_in_ready", 32'(in_ready), 32'd1);
    cyc();
    drive(5'd5, 5'd6, 5'd23);
    for (int k = 2; k < 4; k++) begin
      #1;
      chk($sformatf("bp_c%0d_in_ready", k), 32'(in_ready), 32'd0);
      chk($sformatf("bp_c%0d_out_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("bp_c%0d_rd", k), 32'(out_rd), 32'd21);
      chk($sformatf("bp_c%0d_op_a", k), out_op_a, 32'h10);
      chk($sformatf("bp_c%0d_op_b", k), out_op_b, 32'h20);
      cyc();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("bp_c4_out_valid", 32'(out_valid), 32'd1);
    chk("bp_c4_rd", 32'(out_rd), 32'd21);
    cyc();
    chk("bp_c5_out_valid", 32'(out_valid), 32'd1);
    chk("bp_c5_rd", 32'(out_rd), 32'd22);
    chk("bp_c5_op_a", out_op_a, 32'h30);
    chk("bp_c5_op_b", out_op_b, 32'h40);
    cyc();
    chk("bp_c6_out_valid", 32'(out_valid), 32'd0);

    // Flush with A and B both full and a new offer in the same cycle
    out_ready = 1'b0;
    drive(5'd1, 5'd2, 5'd24);
    cyc();
    drive(5'd3, 5'd4, 5'd25);
    cyc();
    drive(5'd5, 5'd6, 5'd26);
    flush = 1'b1;
    #1;
    chk("fl_in_ready", 32'(in_ready), 32'd1);
    chk("fl_b_full", 32'(out_valid), 32'd1);
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("fl_out_valid_next", 32'(out_valid), 32'd0);
    chk("fl_a_empty", 32'(in_ready), 32'd1);
    cyc();
    chk("fl_nothing_left", 32'(out_valid), 32'd0);
    cyc();

    // Reset in the middle of a stream
    out_ready = 1'b0;
    drive(5'd1, 5'd2, 5'd27);
    cyc();
    drive(5'd3, 5'd4, 5'd28);
    cyc();
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("mr_b_full", 32'(out_valid), 32'd1);
    cyc();
    rst = 1'b1;
    #1;
    chk("mr_out_valid", 32'(out_valid), 32'd0);
    chk("mr_op_a", out_op_a, 32'h0);
    chk("mr_op_b", out_op_b, 32'h0);
    chk("mr_rd", 32'(out_rd), 32'd0);
    chk("mr_ctrl", 32'(out_ctrl), 32'd0);
    chk("mr_imm", out_imm, 32'h0);
    chk("mr_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    cyc();
    chk("mr_stays_empty", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
